// File: rtl/weight_fetcher.sv
// Weight stream producer: fetches bursts of NUM_RDATA packed words from the
// weight memory on request and fans each returned word out to four kernel lanes.
module weight_fetcher #(
  parameter int DAT_WIDTH   = 8,
  parameter int NUM_KERNEL  = 4,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_RDATA   = 3,
  parameter int ADDR_WIDTH  = 12,
  parameter int CNT_WIDTH   = 10,
  parameter int MEM_LAT     = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_start,
  input  logic [ADDR_WIDTH-1:0]                       i_base_addr,
  input  logic [CNT_WIDTH-1:0]                        i_num_groups,
  input  logic                                        i_data_req,
  output logic                                        o_mem_en,
  output logic [ADDR_WIDTH-1:0]                       o_mem_addr,
  input  logic [DAT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_mem_rdata,
  output logic [DAT_WIDTH*NUM_CHANNEL-1:0]            o_data_kn0,
  output logic [DAT_WIDTH*NUM_CHANNEL-1:0]            o_data_kn1,
  output logic [DAT_WIDTH*NUM_CHANNEL-1:0]            o_data_kn2,
  output logic [DAT_WIDTH*NUM_CHANNEL-1:0]            o_data_kn3,
  output logic                                        o_data_kn0_val,
  output logic                                        o_data_kn1_val,
  output logic                                        o_data_kn2_val,
  output logic                                        o_data_kn3_val,
  output logic                                        o_busy,
  output logic                                        o_done
);

  localparam int LANE_W = DAT_WIDTH * NUM_CHANNEL;
  localparam int WORD_W = LANE_W * NUM_KERNEL;
  localparam int BEAT_W = (NUM_RDATA > 1) ? $clog2(NUM_RDATA) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic                  r_pending;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_mem_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_busy;
  logic                  r_done;
  logic [MEM_LAT:0]      r_track;
  logic [WORD_W-1:0]     r_data;
  logic                  w_outstanding;

  // Bit k of r_track is a read issued k+1 cycles ago: bit MEM_LAT-1 marks
  // i_mem_rdata valid now, bit MEM_LAT marks the registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_track <= '0;
    end else begin
      r_track <= {r_track[MEM_LAT-1:0], r_mem_en};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (r_track[MEM_LAT-1]) begin
      r_data <= i_mem_rdata;
    end
  end

  // Reads still waiting for their data; the one landing this cycle is already safe.
  always_comb begin
    w_outstanding = 1'b0;
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      w_outstanding = w_outstanding | r_track[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_pending   <= 1'b0;
      r_beat      <= '0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_remaining <= i_num_groups;
            r_pending   <= 1'b0;
            r_busy      <= 1'b1;
            if (i_num_groups == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_FETCH;
              r_mem_en   <= 1'b1;
              r_mem_addr <= i_base_addr;
              r_beat     <= '0;
            end
          end
        end
        S_FETCH: begin
          if (i_data_req) begin
            r_pending <= 1'b1;
          end
          if (r_beat == BEAT_W'(NUM_RDATA - 1)) begin
            r_mem_en    <= 1'b0;
            r_remaining <= r_remaining - CNT_WIDTH'(1);
            r_state     <= S_DRAIN;
          end else begin
            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            r_beat     <= r_beat + BEAT_W'(1);
          end
        end
        S_DRAIN: begin
          if (i_data_req) begin
            r_pending <= 1'b1;
          end
          if (!w_outstanding) begin
            r_state <= (r_remaining == '0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_data_req || r_pending) begin
            r_pending  <= 1'b0;
            r_state    <= S_FETCH;
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            r_beat     <= '0;
          end
        end
        S_DONE: begin
          // First DONE cycle arms the pulse, second shows it and returns to IDLE.
          r_pending <= 1'b0;
          if (r_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_en       = r_mem_en;
  assign o_mem_addr     = r_mem_addr;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_data_kn0     = r_data[0*LANE_W +: LANE_W];
  assign o_data_kn1     = r_data[1*LANE_W +: LANE_W];
  assign o_data_kn2     = r_data[2*LANE_W +: LANE_W];
  assign o_data_kn3     = r_data[3*LANE_W +: LANE_W];
  assign o_data_kn0_val = r_track[MEM_LAT];
  assign o_data_kn1_val = r_track[MEM_LAT];
  assign o_data_kn2_val = r_track[MEM_LAT];
  assign o_data_kn3_val = r_track[MEM_LAT];

endmodule

// File: tb/tb_weight_fetcher.sv
// Directed bench for weight_fetcher: one instance at MEM_LAT=1, one at MEM_LAT=2,
// each fed by a memory model returning the address zero-extended into every lane.
module tb_weight_fetcher;

  logic        clk;
  logic        rst1, st1, req1, en1, busy1, done1;
  logic [11:0] base1, addr1;
  logic [9:0]  n1;
  logic [95:0] rd1;
  logic [23:0] k10, k11, k12, k13;
  logic        v10, v11, v12, v13;

  logic        rst2, st2, req2, en2, busy2, done2;
  logic [11:0] base2, addr2;
  logic [9:0]  n2;
  logic [95:0] rd2, rd2_s;
  logic [23:0] k20, k21, k22, k23;
  logic        v20, v21, v22, v23;

  int checks = 0;
  int errors = 0;

  logic        e_en   [0:39];
  logic        e_val  [0:39];
  logic        e_busy [0:39];
  logic        e_done [0:39];
  logic        e_z    [0:39];
  logic        d_req  [0:39];
  logic        d_rst  [0:39];
  logic [11:0] e_addr [0:39];
  logic [11:0] e_word [0:39];

  weight_fetcher #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .i_start(st1), .i_base_addr(base1), .i_num_groups(n1),
    .i_data_req(req1), .o_mem_en(en1), .o_mem_addr(addr1), .i_mem_rdata(rd1),
    .o_data_kn0(k10), .o_data_kn1(k11), .o_data_kn2(k12), .o_data_kn3(k13),
    .o_data_kn0_val(v10), .o_data_kn1_val(v11), .o_data_kn2_val(v12), .o_data_kn3_val(v13),
    .o_busy(busy1), .o_done(done1)
  );

  weight_fetcher #(.MEM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst2), .i_start(st2), .i_base_addr(base2), .i_num_groups(n2),
    .i_data_req(req2), .o_mem_en(en2), .o_mem_addr(addr2), .i_mem_rdata(rd2),
    .o_data_kn0(k20), .o_data_kn1(k21), .o_data_kn2(k22), .o_data_kn3(k23),
    .o_data_kn0_val(v20), .o_data_kn1_val(v21), .o_data_kn2_val(v22), .o_data_kn3_val(v23),
    .o_busy(busy2), .o_done(done2)
  );

  function automatic logic [95:0] word_of(input logic [11:0] a);
    return {4{12'h000, a}};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory keeps returning data regardless of enable, so stale reads are visible.
  always @(posedge clk) begin
    rd1   <= word_of(addr1);
    rd2_s <= word_of(addr2);
    rd2   <= rd2_s;
  end

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d observed %h expected %h", tag, c, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 40; i++) begin
      e_en[i] = 0; e_val[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_z[i] = 0;
      d_req[i] = 0; d_rst[i] = 0; e_addr[i] = '0; e_word[i] = '0;
    end
  endtask

  // One group: enables from cycle c0, beats lat+1 cycles after each enable.
  task automatic set_grp(input int c0, input logic [11:0] a0, input int lat);
    for (int k = 0; k < 3; k++) begin
      e_en[c0 + k]             = 1'b1;
      e_addr[c0 + k]           = a0 + 12'(k);
      e_val[c0 + k + lat + 1]  = 1'b1;
      e_word[c0 + k + lat + 1] = a0 + 12'(k);
    end
  endtask

  task automatic set_busy(input int from, input int to);
    for (int i = from; i <= to; i++) e_busy[i] = 1'b1;
  endtask

  task automatic drive(input int sel, input logic s, input logic [11:0] b, input logic [9:0] n,
                       input logic r, input logic x);
    if (sel == 1) begin
      st1 = s; base1 = b; n1 = n; req1 = r; rst1 = x;
    end else begin
      st2 = s; base2 = b; n2 = n; req2 = r; rst2 = x;
    end
  endtask

  task automatic check_cycle(input int sel, input int c);
    logic        en, busy, done;
    logic [3:0]  val;
    logic [11:0] addr;
    logic [23:0] k [4];
    logic [23:0] lane;
    if (sel == 1) begin
      en = en1; busy = busy1; done = done1; addr = addr1;
      val = {v13, v12, v11, v10};
      k[0] = k10; k[1] = k11; k[2] = k12; k[3] = k13;
    end else begin
      en = en2; busy = busy2; done = done2; addr = addr2;
      val = {v23, v22, v21, v20};
      k[0] = k20; k[1] = k21; k[2] = k22; k[3] = k23;
    end
    lane = {12'h000, e_word[c]};
    chk("mem_en", c, 32'(en), 32'(e_en[c]));
    chk("busy", c, 32'(busy), 32'(e_busy[c]));
    chk("done", c, 32'(done), 32'(e_done[c]));
    chk("val", c, 32'(val), 32'({4{e_val[c]}}));
    if (e_en[c] || e_z[c]) chk("mem_addr", c, 32'(addr), 32'(e_addr[c]));
    if (e_val[c] || e_z[c]) begin
      for (int i = 0; i < 4; i++) chk($sformatf("kn%0d", i), c, 32'(k[i]), 32'(lane));
    end
  endtask

  // Cycle 0 carries i_start; checks run from cycle 1, each #1 after the edge.
  task automatic run(input int sel, input logic [11:0] b, input logic [9:0] n, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      drive(sel, c == 0, b, n, d_req[c], d_rst[c]);
      if (c > 0) check_cycle(sel, c);
    end
  endtask

  initial begin
    rst1 = 1; st1 = 0; base1 = '0; n1 = '0; req1 = 0;
    rst2 = 1; st2 = 0; base2 = '0; n2 = '0; req2 = 0;
    repeat (3) @(posedge clk);
    #1;
    clr();
    e_z[0] = 1'b1;
    check_cycle(1, 0);
    check_cycle(2, 0);
    rst1 = 0;
    rst2 = 0;

    // Single group, L=1
    clr(); set_grp(1, 12'h010, 1); set_busy(1, 6); e_done[6] = 1;
    run(1, 12'h010, 10'd1, 8);

    // Three groups, requests two cycles into each WAIT
    clr(); set_grp(1, 12'h100, 1); set_grp(8, 12'h103, 1); set_grp(15, 12'h106, 1);
    d_req[7] = 1; d_req[14] = 1; set_busy(1, 20); e_done[20] = 1;
    run(1, 12'h100, 10'd3, 22);

    // Zero-group job
    clr(); set_busy(1, 2); e_done[2] = 1;
    run(1, 12'h055, 10'd0, 4);

    // Two requests during FETCH collapse into one pending group
    clr(); d_req[1] = 1; d_req[3] = 1; d_req[13] = 1;
    set_grp(1, 12'h040, 1); set_grp(6, 12'h043, 1); set_grp(14, 12'h046, 1);
    set_busy(1, 19); e_done[19] = 1;
    run(1, 12'h040, 10'd3, 21);

    // Address wrap
    clr(); set_grp(1, 12'hFFE, 1); set_busy(1, 6); e_done[6] = 1;
    run(1, 12'hFFE, 10'd1, 8);

    // Reset in the second FETCH cycle, L=2: nothing may leak out afterwards
    clr(); e_en[1] = 1; e_en[2] = 1; e_addr[1] = 12'h200; e_addr[2] = 12'h201;
    set_busy(1, 2); d_rst[2] = 1;
    for (int i = 3; i < 10; i++) e_z[i] = 1'b1;
    run(2, 12'h200, 10'd2, 10);

    // Fresh start after reset, L=2
    clr(); set_grp(1, 12'h010, 2); set_busy(1, 7); e_done[7] = 1;
    run(2, 12'h010, 10'd1, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
